umi_mem_responder: RTL and testbench
====================================

// Module: umi_mem_responder
// PURPOSE
// - UMI target endpoint on a crossbar output port: accepts read / write requests, services them
//   from an internal DEPTH x DW memory and returns UMI responses on the reverse channel.
// - Response is routed back by swapping addresses: response dstaddr = request srcaddr.
// - Used as the far-end agent behind umi_crossbar in simulation and as a small on-chip scratchpad.
// PARAMETERS
// - CW     32   command width
// - AW     64   address width
// - DW     64   data / memory word width, power of two, >= 8; OB = log2(DW/8) byte-offset bits
// - DEPTH  256  memory words, power of two; IW = log2(DEPTH)
// PORTS
// - clk              in   1    clock
// - reset            in   1    asynchronous, active-high reset
// - umi_in_valid     in   1    request valid
// - umi_in_ready     out  1    request ready
// - umi_in_cmd       in   CW   request command
// - umi_in_dstaddr   in   AW   request target address
// - umi_in_srcaddr   in   AW   requester return address
// - umi_in_data      in   DW   write data, LSB-aligned
// - umi_out_valid    out  1    response valid
// - umi_out_ready    in   1    response ready
// - umi_out_cmd      out  CW   response command
// - umi_out_dstaddr  out  AW   = captured request srcaddr
// - umi_out_srcaddr  out  AW   = captured request dstaddr
// - umi_out_data     out  DW   read data, LSB-aligned, unused upper bytes zero
// - err_count        out  16   saturating count of errored requests
// BEHAVIOUR
// - cmd[4:0] opcode: 01 READ, 02 WRITE (acked), 03 POSTED; responses 08 RESP_READ, 09 RESP_WRITE,
//   0F RESP_ERR. cmd[7:5] SIZE (2^SIZE bytes). cmd[15:8] TAG, echoed. Response cmd[CW-1:16]=0.
// - Reset: umi_out_valid=0, umi_in_ready=1, err_count=0, all out fields 0; memory NOT reset.
// - FSM IDLE/RESP. umi_in_ready=1 only in IDLE. Transfer = valid & ready on rising clk.
// - IDLE + READ/WRITE accepted -> RESP; umi_out_valid=1 the next cycle (1-cycle latency).
// - IDLE + POSTED accepted -> write performed, stay IDLE; back-to-back posted writes every cycle.
// - RESP: outputs held stable until umi_out_valid & umi_out_ready -> IDLE; in_ready stays 0 that
//   cycle, so next request is accepted at earliest one cycle after the response transfer.
// - Address: offset = dstaddr[39:0]; word index = dstaddr[OB+:IW]; lane = dstaddr[OB-1:0].
//   dstaddr[AW-1:40] ignored (routing done upstream).
// - Error if: opcode not 01/02/03; SIZE > OB; lane not multiple of 2^SIZE; dstaddr[39:OB+IW] != 0.
//   Errored READ/WRITE -> RESP_ERR, data 0, memory untouched. Errored POSTED -> dropped, no response.
//   Every error increments err_count (saturates at 16'hFFFF).
// - Write: bytes [0 .. 2^SIZE-1] of umi_in_data written to byte lanes lane..lane+2^SIZE-1; others kept.
// - Read: bytes at lane..lane+2^SIZE-1 returned at data LSB, rest 0. Memory read at accept edge,
//   so read after a posted write to same word (next cycle or later) sees new data.
// - Reset asserted mid-RESP: pending response discarded, umi_out_valid=0 immediately (async).
// TESTING
// - Reset -> umi_out_valid=0, umi_in_ready=1, err_count=0.
// - POSTED SIZE3 @0x10 data 64'h1122334455667788; READ SIZE3 @0x10 TAG 5A srcaddr 64'h0001_0000_0000_0000
//   -> 1 cycle later RESP_READ, data 64'h1122334455667788, out_dstaddr 64'h0001_0000_0000_0000, TAG 5A.
// - POSTED SIZE0 @0x13 data 8'hAB; READ SIZE3 @0x10 -> 64'h11223344AB667788; READ SIZE1 @0x12 -> 64'hAB66.
// - WRITE @0x18 with umi_out_ready=0 for 5 cycles -> RESP_WRITE held stable, umi_in_ready=0;
//   ready=1 -> transfer, new request accepted the following cycle.
// - READ @0x800 -> RESP_ERR, err_count=1; READ SIZE1 @0x11 -> RESP_ERR, err_count=2;
//   POSTED @0x800 -> no response, err_count=3; opcode 05 -> RESP_ERR, err_count=4.
// - Assert reset while umi_out_valid=1 -> umi_out_valid=0, umi_in_ready=1 after release, err_count=0.

Source files
------------

// File: rtl/umi_mem_responder_if.sv
// UMI channel bundle: one valid/ready request or response stream.
// master drives the payload, slave returns ready.
interface umi_mem_responder_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          valid;
  logic          ready;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;

  modport master (
    output valid, cmd, dstaddr, srcaddr, data,
    input  ready
  );

  modport slave (
    input  valid, cmd, dstaddr, srcaddr, data,
    output ready
  );
endinterface

// File: rtl/umi_mem_responder.sv
// UMI target endpoint: services read/write/posted requests from a
// local byte-addressable memory and returns address-swapped responses.
module umi_mem_responder #(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int DEPTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  umi_mem_responder_if.slave  umi_in,
  umi_mem_responder_if.master umi_out,
  output logic [15:0]         err_count
);

  localparam int OB = $clog2(DW/8);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = DW/8;

  localparam logic [4:0] OP_READ   = 5'h01;
  localparam logic [4:0] OP_WRITE  = 5'h02;
  localparam logic [4:0] OP_POSTED = 5'h03;
  localparam logic [4:0] RSP_READ  = 5'h08;
  localparam logic [4:0] RSP_WRITE = 5'h09;
  localparam logic [4:0] RSP_ERR   = 5'h0F;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t        state;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [CW-1:0] out_cmd_q;
  logic [AW-1:0] out_dst_q;
  logic [AW-1:0] out_src_q;
  logic [DW-1:0] out_data_q;

  logic [4:0]    op;
  logic [2:0]    size;
  logic [7:0]    tag;
  logic [39:0]   off;
  logic [OB-1:0] lane;
  logic [IW-1:0] idx;

  assign op   = umi_in.cmd[4:0];
  assign size = umi_in.cmd[7:5];
  assign tag  = umi_in.cmd[15:8];
  assign off  = umi_in.dstaddr[39:0];
  assign lane = off[OB-1:0];
  assign idx  = off[OB+:IW];

  logic unused;
  assign unused = ^{umi_in.dstaddr[AW-1:40],
                    umi_in.cmd[CW-1:16]};

  logic op_err, size_err, align_err, hi_err, err;
  logic is_posted, is_write, accept, do_write;

  assign op_err    = !(op == OP_READ || op == OP_WRITE ||
                       op == OP_POSTED);
  assign size_err  = int'(size) > OB;
  assign align_err = (int'(lane) & ((1 << size) - 1)) != 0;
  assign hi_err    = (off >> (OB + IW)) != 40'd0;
  assign err       = op_err | size_err | align_err | hi_err;

  assign is_posted = (op == OP_POSTED);
  assign is_write  = (op == OP_WRITE) || is_posted;
  assign accept    = umi_in.valid & in_ready_q;
  assign do_write  = accept & is_write & !err;

  logic [NB-1:0] be;
  logic [DW-1:0] rmask;

  // Lane window of the access and the LSB-aligned read mask.
  always_comb begin
    be    = '0;
    rmask = '0;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(lane) && b < int'(lane) + (1 << size))
        be[b] = 1'b1;
      if (b < (1 << size))
        rmask[b*8 +: 8] = 8'hFF;
    end
  end

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wdata;
  logic [DW-1:0] rword;
  logic [DW-1:0] rdata;

  assign wdata = umi_in.data << {lane, 3'b000};
  assign rword = mem[idx];
  assign rdata = (rword >> {lane, 3'b000}) & rmask;

  // Storage is intentionally left uninitialised across reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (do_write && be[b])
        mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  logic [4:0] rsp_op;

  always_comb begin
    rsp_op = RSP_WRITE;
    if (err)
      rsp_op = RSP_ERR;
    else if (op == OP_READ)
      rsp_op = RSP_READ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      err_count   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (err && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            if (!is_posted) begin
              state       <= S_RESP;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_cmd_q   <= {{(CW-16){1'b0}}, tag,
                              size, rsp_op};
              out_dst_q   <= umi_in.srcaddr;
              out_src_q   <= umi_in.dstaddr;
              out_data_q  <= (err || op != OP_READ) ?
                             '0 : rdata;
            end
          end
        end
        S_RESP: begin
          // ready returns only after the response has left.
          if (umi_out.ready) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign umi_in.ready    = in_ready_q;
  assign umi_out.valid   = out_valid_q;
  assign umi_out.cmd     = out_cmd_q;
  assign umi_out.dstaddr = out_dst_q;
  assign umi_out.srcaddr = out_src_q;
  assign umi_out.data    = out_data_q;

endmodule

// File: tb/tb_umi_mem_responder.sv
// Bench for umi_mem_responder: vector table plus response scoreboard
// and hand-written backpressure, back-to-back and reset sequences.
module tb_umi_mem_responder;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  umi_mem_responder_if #(.CW(CW), .AW(AW), .DW(DW)) umi_in ();
  umi_mem_responder_if #(.CW(CW), .AW(AW), .DW(DW)) umi_out ();

  umi_mem_responder #(
    .CW(CW), .AW(AW), .DW(DW), .DEPTH(256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .umi_in    (umi_in),
    .umi_out   (umi_out),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
    bit          rsp;
    logic [31:0] rcmd;
    logic [63:0] rdata;
    logic [15:0] errs;
  } vec_t;

  typedef struct {
    logic [31:0] cmd;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mk(
    logic [4:0] op, logic [2:0] sz, logic [7:0] tag);
    return {16'h0, tag, sz, op};
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request and hold it until accepted (bounded).
  task automatic send(logic [31:0] cmd, logic [63:0] dst,
                      logic [63:0] src, logic [63:0] data,
                      output bit ok);
    int n;
    @(negedge clk);
    umi_in.valid   = 1'b1;
    umi_in.cmd     = cmd;
    umi_in.dstaddr = dst;
    umi_in.srcaddr = src;
    umi_in.data    = data;
    n = 0;
    while (!umi_in.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!umi_in.ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
      umi_in.valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1 umi_in.valid = 1'b0;
    ok = 1'b1;
  endtask

  always @(negedge clk) begin : mon
    rsp_t e;
    if (reset === 1'b0 && umi_out.valid === 1'b1 &&
        umi_out.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got cmd %h expected none",
                 umi_out.cmd);
      end else begin
        e = sb.pop_front();
        chk("rsp_cmd", 64'(umi_out.cmd), 64'(e.cmd));
        chk("rsp_dst", umi_out.dstaddr, e.dst);
        chk("rsp_src", umi_out.srcaddr, e.src);
        chk("rsp_data", umi_out.data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  localparam logic [63:0] S = 64'h0001_0000_0000_0000;
  localparam int NV = 21;
  vec_t v [NV];

  initial begin
    bit ok;
    logic [31:0] hold_cmd;

    v[0]  = '{mk(3,3,0), 64'h10, S, 64'h1122334455667788,
              0, 0, 0, 0};
    v[1]  = '{mk(1,3,8'h5A), 64'h10, S, 0,
              1, mk(8,3,8'h5A), 64'h1122334455667788, 0};
    v[2]  = '{mk(3,0,0), 64'h13, S, 64'hAB, 0, 0, 0, 0};
    v[3]  = '{mk(1,3,1), 64'h10, S+1, 0,
              1, mk(8,3,1), 64'h11223344AB667788, 0};
    v[4]  = '{mk(1,1,2), 64'h12, S+2, 0,
              1, mk(8,1,2), 64'hAB66, 0};
    v[5]  = '{mk(1,0,3), 64'h17, S+3, 0,
              1, mk(8,0,3), 64'h11, 0};
    v[6]  = '{mk(2,2,4), 64'h14, S+4, 64'hFFFFFFFF_DEADBEEF,
              1, mk(9,2,4), 0, 0};
    v[7]  = '{mk(1,3,5), 64'h10, S+5, 0,
              1, mk(8,3,5), 64'hDEADBEEF_AB667788, 0};
    v[8]  = '{mk(3,3,0), 64'hFF00_0000_0000_0020, S,
              64'h0102030405060708, 0, 0, 0, 0};
    v[9]  = '{mk(3,1,0), 64'h22, S, 64'hFFFF_FFFF_FFFF_1234,
              0, 0, 0, 0};
    v[10] = '{mk(1,2,6), 64'h20, S+6, 0,
              1, mk(8,2,6), 64'h12340708, 0};
    v[11] = '{mk(2,3,7), 64'h7F8, S+7, 64'hCAFEF00D_12345678,
              1, mk(9,3,7), 0, 0};
    v[12] = '{mk(1,3,8), 64'h7F8, S+8, 0,
              1, mk(8,3,8), 64'hCAFEF00D_12345678, 0};
    v[13] = '{mk(1,3,9), 64'h800, S+9, 0,
              1, mk(15,3,9), 0, 1};
    v[14] = '{mk(1,1,10), 64'h11, S+10, 0,
              1, mk(15,1,10), 0, 2};
    v[15] = '{mk(3,3,0), 64'h800, S, 64'h55, 0, 0, 0, 3};
    v[16] = '{mk(5,3,11), 64'h10, S+11, 0,
              1, mk(15,3,11), 0, 4};
    v[17] = '{mk(1,4,12), 64'h10, S+12, 0,
              1, mk(15,4,12), 0, 5};
    v[18] = '{mk(1,3,13), 64'h10, S+13, 0,
              1, mk(8,3,13), 64'hDEADBEEF_AB667788, 5};
    v[19] = '{mk(2,2,14), 64'h12, S+14, 64'h0,
              1, mk(15,2,14), 0, 6};
    v[20] = '{mk(1,3,15), 64'h10, S+15, 0,
              1, mk(8,3,15), 64'hDEADBEEF_AB667788, 6};

    reset          = 1'b1;
    umi_in.valid   = 1'b0;
    umi_in.cmd     = '0;
    umi_in.dstaddr = '0;
    umi_in.srcaddr = '0;
    umi_in.data    = '0;
    umi_out.ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(umi_out.valid), 64'd0);
    chk("rst_ready", 64'(umi_in.ready), 64'd1);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_cmd", 64'(umi_out.cmd), 64'd0);
    chk("rst_dst", umi_out.dstaddr, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send(v[i].cmd, v[i].dst, v[i].src, v[i].data, ok);
      if (ok && v[i].rsp)
        sb.push_back('{v[i].rcmd, v[i].src, v[i].dst,
                       v[i].rdata});
      @(negedge clk);
      chk($sformatf("v%0d_err", i), 64'(err_count),
          64'(v[i].errs));
      chk($sformatf("v%0d_lat", i), 64'(umi_out.valid),
          64'(v[i].rsp));
    end

    // Back-to-back posted writes, then a read the next cycle.
    @(negedge clk);
    umi_in.valid   = 1'b1;
    umi_in.cmd     = mk(3,3,0);
    umi_in.dstaddr = 64'h30;
    umi_in.data    = 64'hA0A1A2A3A4A5A6A7;
    chk("b2b_rdy0", 64'(umi_in.ready), 64'd1);
    @(posedge clk);
    #1 umi_in.dstaddr = 64'h38;
    umi_in.data = 64'hB0B1B2B3B4B5B6B7;
    @(negedge clk);
    chk("b2b_rdy1", 64'(umi_in.ready), 64'd1);
    @(posedge clk);
    #1 umi_in.cmd = mk(1,3,8'h21);
    umi_in.srcaddr = S + 64'h21;
    @(negedge clk);
    chk("b2b_rdy2", 64'(umi_in.ready), 64'd1);
    @(posedge clk);
    #1 umi_in.valid = 1'b0;
    sb.push_back('{mk(8,3,8'h21), S + 64'h21, 64'h38,
                   64'hB0B1B2B3B4B5B6B7});
    send(mk(1,3,8'h22), 64'h30, S + 64'h22, 0, ok);
    if (ok)
      sb.push_back('{mk(8,3,8'h22), S + 64'h22, 64'h30,
                     64'hA0A1A2A3A4A5A6A7});
    @(negedge clk);

    // Backpressure: response held stable, ready low.
    @(posedge clk);
    #1 umi_out.ready = 1'b0;
    hold_cmd = mk(9,3,8'h77);
    send(mk(2,3,8'h77), 64'h18, S + 64'h77,
         64'h0F0E0D0C0B0A0908, ok);
    if (ok)
      sb.push_back('{hold_cmd, S + 64'h77, 64'h18, 64'h0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 64'(umi_out.valid), 1);
      chk($sformatf("hold%0d_cmd", k), 64'(umi_out.cmd),
          64'(hold_cmd));
      chk($sformatf("hold%0d_dst", k), umi_out.dstaddr,
          S + 64'h77);
      chk($sformatf("hold%0d_rdy", k), 64'(umi_in.ready), 0);
    end
    @(posedge clk);
    #1 umi_out.ready = 1'b1;
    @(negedge clk);
    chk("xfer_rdy", 64'(umi_in.ready), 64'd0);
    umi_in.valid   = 1'b1;
    umi_in.cmd     = mk(1,3,8'h78);
    umi_in.dstaddr = 64'h18;
    umi_in.srcaddr = S + 64'h78;
    @(negedge clk);
    chk("post_xfer_rdy", 64'(umi_in.ready), 64'd1);
    chk("post_xfer_valid", 64'(umi_out.valid), 64'd0);
    @(posedge clk);
    #1 umi_in.valid = 1'b0;
    sb.push_back('{mk(8,3,8'h78), S + 64'h78, 64'h18,
                   64'h0F0E0D0C0B0A0908});
    @(negedge clk);
    chk("post_xfer_lat", 64'(umi_out.valid), 64'd1);

    // Reset while a response is pending.
    @(posedge clk);
    #1 umi_out.ready = 1'b0;
    send(mk(1,3,8'h33), 64'h10, S, 0, ok);
    @(negedge clk);
    chk("pend_valid", 64'(umi_out.valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(umi_out.valid), 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    umi_out.ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(umi_in.ready), 64'd1);
    chk("rel_valid", 64'(umi_out.valid), 64'd0);
    send(mk(1,3,8'h34), 64'h10, S + 64'h34, 0, ok);
    if (ok)
      sb.push_back('{mk(8,3,8'h34), S + 64'h34, 64'h10,
                     64'hDEADBEEF_AB667788});
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
